// File: rtl/spi_cmd_feeder.sv
// spi_cmd_feeder
//   Buffers {dc, byte} entries in a small FIFO and replays each one to a
//   memory-mapped SPI controller over a single-master AHB-Lite port:
//   DC register, DATA register, START register, then STATUS polling until
//   the controller reports idle. Initialises DELAY and NB registers after reset.
//
// Parameters
//   BASE_ADDR  : AHB base address of the SPI register block.
//   FIFO_DEPTH : input FIFO entries (power of two, 2..64).
//   SPI_DELAY  : value written to the DELAY register at init.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset.
//   in_valid/in_ready       : byte input handshake; in_data byte, in_dc D/C level.
//   ahb_m_*_o               : AHB master request outputs (all registered).
//   ahb_m_hready_i/hresp_i  : slave handshake / error response.
//   ahb_m_hrdata_i          : read data, bit 0 = SPI idle.
//   busy                    : FIFO non-empty or sequencer active.
//   err                     : sticky error-response flag.
//
// Optional feature
//   SPI_FEEDER_DC_CACHE_EN  : when defined, skip the DC write if the last
//                             written DC level already matches the entry.

module spi_cmd_feeder #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] SPI_DELAY  = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_dc,
  output logic [31:0] ahb_m_haddr_o,
  output logic        ahb_m_hwrite_o,
  output logic [1:0]  ahb_m_htrans_o,
  output logic [2:0]  ahb_m_hsize_o,
  output logic [2:0]  ahb_m_hburst_o,
  output logic [3:0]  ahb_m_hprot_o,
  output logic        ahb_m_hmastlock_o,
  output logic [31:0] ahb_m_hwdata_o,
  input  logic        ahb_m_hready_i,
  input  logic        ahb_m_hresp_i,
  input  logic [31:0] ahb_m_hrdata_i,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  HT_IDLE = 2'b00;
  localparam logic [1:0]  HT_NSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_INIT_DLY = 3'd0, S_INIT_NB = 3'd1, S_IDLE = 3'd2, S_WR_DC = 3'd3,
    S_WR_DATA  = 3'd4, S_WR_START = 3'd5, S_POLL = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;     // 0 = address phase, 1 = data phase
  logic        start_q, start_d;     // first post-reset cycle only presents INIT_DLY
  logic [8:0]  hold_q, hold_d;       // {dc, data} of the byte in flight
  logic        err_q, err_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  htrans_q, htrans_d;

  // FIFO storage and pointers
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_s, pop_s, skip_dc_s;
  logic [8:0]    head_s;
  logic          unused_hrdata_s;

  assign in_ready        = (count_q != DEPTH_C);
  assign push_s          = in_valid && in_ready;
  assign head_s          = mem_q[rptr_q];
  assign unused_hrdata_s = ^ahb_m_hrdata_i[31:1];

`ifdef SPI_FEEDER_DC_CACHE_EN
  logic dc_valid_q, dc_valid_d, dc_last_q, dc_last_d;
  assign skip_dc_s = dc_valid_q && (dc_last_q == head_s[8]);

  // DC cache: remember the level of every completed DC write
  always_comb begin
    dc_valid_d = dc_valid_q;
    dc_last_d  = dc_last_q;
    if (start_q && ahb_m_hready_i && (state_q == S_WR_DC) && phase_q) begin
      dc_valid_d = 1'b1;
      dc_last_d  = hold_q[8];
    end else begin
      dc_valid_d = dc_valid_q;
    end
  end

  // DC cache registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dc_valid_q <= 1'b0;
      dc_last_q  <= 1'b0;
    end else begin
      dc_valid_q <= dc_valid_d;
      dc_last_q  <= dc_last_d;
    end
  end
`else
  assign skip_dc_s = 1'b0;
`endif

  // Sequencer next state, pop request and sticky error
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start_d = 1'b1;
    hold_d  = hold_q;
    pop_s   = 1'b0;
    err_d   = err_q;
    if (!start_q) begin
      state_d = state_q;                    // present INIT_DLY address phase first
    end else if (state_q == S_IDLE) begin
      if (count_q != {(AW+1){1'b0}}) begin
        pop_s   = 1'b1;
        hold_d  = head_s;
        state_d = skip_dc_s ? S_WR_DATA : S_WR_DC;
        phase_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (ahb_m_hready_i) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        case (state_q)
          S_INIT_DLY: state_d = S_INIT_NB;
          S_INIT_NB:  state_d = S_IDLE;
          S_WR_DC:    state_d = S_WR_DATA;
          S_WR_DATA:  state_d = S_WR_START;
          S_WR_START: state_d = S_POLL;
          S_POLL:     state_d = ahb_m_hrdata_i[0] ? S_IDLE : S_POLL;
          default:    state_d = S_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;                    // slave stall: hold everything
    end
    if (start_q && (state_q != S_IDLE) && phase_q && ahb_m_hresp_i) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Bus request for the phase being entered; IDLE keeps the last address/data
  always_comb begin
    htrans_d = HT_IDLE;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    if (state_d != S_IDLE) begin
      htrans_d = phase_d ? HT_IDLE : HT_NSEQ;
      hwrite_d = 1'b1;
      case (state_d)
        S_INIT_DLY: begin haddr_d = BASE_ADDR + 32'h04; hwdata_d = {16'h0000, SPI_DELAY}; end
        S_INIT_NB:  begin haddr_d = BASE_ADDR + 32'h08; hwdata_d = 32'd7; end
        S_WR_DC:    begin haddr_d = BASE_ADDR + 32'h0C; hwdata_d = {31'd0, hold_d[8]}; end
        S_WR_DATA:  begin haddr_d = BASE_ADDR + 32'h00; hwdata_d = {24'd0, hold_d[7:0]}; end
        S_WR_START: begin haddr_d = BASE_ADDR + 32'h10; hwdata_d = 32'd1; end
        S_POLL:     begin haddr_d = BASE_ADDR + 32'h14; hwdata_d = 32'd0; hwrite_d = 1'b0; end
        default:    begin haddr_d = haddr_q; end
      endcase
    end else begin
      htrans_d = HT_IDLE;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wptr_d  = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = pop_s  ? (rptr_q + AW'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {in_dc, in_data};
    end
  end

  // State, FIFO control and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INIT_DLY;
      phase_q  <= 1'b0;
      start_q  <= 1'b0;
      hold_q   <= 9'd0;
      err_q    <= 1'b0;
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      htrans_q <= HT_IDLE;
      haddr_q  <= 32'd0;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      start_q  <= start_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign ahb_m_htrans_o    = htrans_q;
  assign ahb_m_haddr_o     = haddr_q;
  assign ahb_m_hwrite_o    = hwrite_q;
  assign ahb_m_hwdata_o    = hwdata_q;
  assign ahb_m_hsize_o     = 3'b010;
  assign ahb_m_hburst_o    = 3'b000;
  assign ahb_m_hprot_o     = 4'b0011;
  assign ahb_m_hmastlock_o = 1'b0;
  assign err               = err_q;
  assign busy              = (count_q != {(AW+1){1'b0}}) || (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_feeder.sv
module tb_spi_cmd_feeder;
  localparam logic [31:0] BASE = 32'hC000_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_dc = 1'b0, in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, busy, err;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hready = 1'b1, hresp = 1'b0;

  int n_vec = 0, n_err = 0;
  int idle_after = 0;    // slave reports idle after this many not-idle polls
  int poll_cnt;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
  typedef struct { logic [1:0] htrans; logic addr_chk; logic [31:0] haddr;
                   logic wd_chk; logic [31:0] hwdata; logic busy; } cyc_t;
  xfer_t log_q[$];
  logic        pend_q = 1'b0, pwr_q = 1'b0;
  logic [31:0] paddr_q = 32'h0;

  always #5 clk = ~clk;

  spi_cmd_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dc(in_dc), .ahb_m_haddr_o(haddr), .ahb_m_hwrite_o(hwrite),
    .ahb_m_htrans_o(htrans), .ahb_m_hsize_o(hsize), .ahb_m_hburst_o(hburst),
    .ahb_m_hprot_o(hprot), .ahb_m_hmastlock_o(hmastlock), .ahb_m_hwdata_o(hwdata),
    .ahb_m_hready_i(hready), .ahb_m_hresp_i(hresp), .ahb_m_hrdata_i(hrdata),
    .busy(busy), .err(err)
  );

  assign hrdata = {31'd0, (poll_cnt >= idle_after)};

  // Bus monitor and status-register slave model
  always @(posedge clk) begin
    if (reset) begin
      pend_q   <= 1'b0;
      poll_cnt <= 0;
    end else if (hready) begin
      if (pend_q) begin
        log_q.push_back('{paddr_q, pwr_q, (pwr_q ? hwdata : hrdata)});
        if (!pwr_q) poll_cnt <= hrdata[0] ? 0 : poll_cnt + 1;
      end
      pend_q <= (htrans == 2'b10);
      if (htrans == 2'b10) begin
        paddr_q <= haddr;
        pwr_q   <= hwrite;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
  endtask

  task automatic check_init(input cyc_t tab[5]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("init%0d_htrans", c + 1), 32'(htrans), 32'(tab[c].htrans));
      if (tab[c].addr_chk) begin
        chk($sformatf("init%0d_haddr", c + 1), haddr, tab[c].haddr);
        chk($sformatf("init%0d_hwrite", c + 1), 32'(hwrite), 32'd1);
      end
      if (tab[c].wd_chk) chk($sformatf("init%0d_hwdata", c + 1), hwdata, tab[c].hwdata);
      chk($sformatf("init%0d_busy", c + 1), 32'(busy), 32'(tab[c].busy));
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (busy && k < max) begin @(negedge clk); k++; end
    chk(name, 32'(k < max), 32'd1);
  endtask

  task automatic push1(input logic dc, input logic [7:0] d);
    in_valid = 1'b1; in_dc = dc; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    cyc_t  init_tab[5];
    xfer_t exp20[7];
    xfer_t exp22[4];
    logic [7:0] seen[$];
    logic [7:0] dcs[$];
    int k, bc;
    logic [7:0] exp_dc[3];
    int n_dc_exp;

    init_tab[0] = '{2'b10, 1'b1, BASE + 32'h04, 1'b0, 32'h0, 1'b1};
    init_tab[1] = '{2'b00, 1'b1, BASE + 32'h04, 1'b1, 32'h4, 1'b1};
    init_tab[2] = '{2'b10, 1'b1, BASE + 32'h08, 1'b0, 32'h0, 1'b1};
    init_tab[3] = '{2'b00, 1'b1, BASE + 32'h08, 1'b1, 32'h7, 1'b1};
    init_tab[4] = '{2'b00, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0};
    exp20[0] = '{BASE + 32'h0C, 1'b1, 32'h0};
    exp20[1] = '{BASE + 32'h00, 1'b1, 32'hAE};
    exp20[2] = '{BASE + 32'h10, 1'b1, 32'h1};
    for (int i = 3; i < 6; i++) exp20[i] = '{BASE + 32'h14, 1'b0, 32'h0};
    exp20[6] = '{BASE + 32'h14, 1'b0, 32'h1};
    exp22[0] = '{BASE + 32'h0C, 1'b1, 32'h1};
    exp22[1] = '{BASE + 32'h00, 1'b1, 32'h5A};
    exp22[2] = '{BASE + 32'h10, 1'b1, 32'h1};
    exp22[3] = '{BASE + 32'h14, 1'b0, 32'h1};
`ifdef SPI_FEEDER_DC_CACHE_EN
    exp_dc = '{8'd1, 8'd0, 8'd0}; n_dc_exp = 2;
`else
    exp_dc = '{8'd1, 8'd1, 8'd0}; n_dc_exp = 3;
`endif

    // Reset release and init sequence, cycle exact
    do_reset();
    check_init(init_tab);

    // Single byte with three not-idle polls
    log_q.delete();
    idle_after = 3;
    in_valid = 1'b1; in_dc = 1'b0; in_data = 8'hAE;
    chk("b1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    bc = 0; k = 0;
    while (busy && k < 100) begin bc++; @(negedge clk); k++; end
    chk("b1_busy_cycles", 32'(bc), 32'd15);
    chk("b1_nxfers", 32'(log_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("b1_x%0d_addr", i), log_q[i].addr, exp20[i].addr);
        chk($sformatf("b1_x%0d_wr", i), 32'(log_q[i].wr), 32'(exp20[i].wr));
        chk($sformatf("b1_x%0d_data", i), log_q[i].data, exp20[i].data);
      end
    end

    // Five-cycle stall in the WR_DATA data phase
    log_q.delete();
    idle_after = 0;
    push1(1'b1, 8'h5A);
    k = 0;
    while (!(htrans == 2'b00 && haddr == BASE) && k < 50) begin @(negedge clk); k++; end
    chk("stall_found", 32'(k < 50), 32'd1);
    hready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_haddr", haddr, BASE);
      chk("stall_htrans", 32'(htrans), 32'd0);
      chk("stall_hwdata", hwdata, 32'h5A);
    end
    hready = 1'b1;
    wait_idle("stall_done", 100);
    chk("stall_nxfers", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("stall_x%0d_addr", i), log_q[i].addr, exp22[i].addr);
        chk($sformatf("stall_x%0d_data", i), log_q[i].data, exp22[i].data);
      end
    end

    // FIFO full: nine bytes while the sequencer is held in INIT
    hready = 1'b0;
    do_reset();
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_dc = 1'b0; in_data = 8'h10 + 8'(i);
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_data = 8'h18;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    hready = 1'b1; idle_after = 1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("ninth_accepted", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("full_done", 2000);
    foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == BASE) seen.push_back(log_q[i].data[7:0]);
    chk("full_nbytes", 32'(seen.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < seen.size()) chk($sformatf("full_byte%0d", i), 32'(seen[i]), 32'h10 + 32'(i));

    // DC writes for {1,11},{1,22},{0,33} pushed back to back
    log_q.delete(); seen.delete();
    idle_after = 0;
    bc = 0;
    in_valid = 1'b1; in_dc = 1'b1; in_data = 8'h11; @(negedge clk); bc += int'(busy);
    in_data = 8'h22; @(negedge clk); bc += int'(busy);
    in_dc = 1'b0; in_data = 8'h33; @(negedge clk); bc += int'(busy);
    in_valid = 1'b0;
    k = 0;
    while (busy && k < 200) begin @(negedge clk); bc += int'(busy); k++; end
    chk("dc_busy_cycles", 32'(bc), (n_dc_exp == 3) ? 32'd27 : 32'd25);
    foreach (log_q[i]) begin
      if (log_q[i].wr && log_q[i].addr == BASE + 32'h0C) dcs.push_back(log_q[i].data[7:0]);
      if (log_q[i].wr && log_q[i].addr == BASE) seen.push_back(log_q[i].data[7:0]);
    end
    chk("dc_nwrites", 32'(dcs.size()), 32'(n_dc_exp));
    for (int i = 0; i < 3; i++)
      if (i < dcs.size() && i < n_dc_exp) chk($sformatf("dc_val%0d", i), 32'(dcs[i]), 32'(exp_dc[i]));
    chk("dc_nbytes", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("dc_byte0", 32'(seen[0]), 32'h11);
      chk("dc_byte1", 32'(seen[1]), 32'h22);
      chk("dc_byte2", 32'(seen[2]), 32'h33);
    end

    // Error response in WR_START, then reset during POLL
    idle_after = 1000;
    push1(1'b0, 8'h77);
    k = 0;
    while (!(htrans == 2'b00 && haddr == BASE + 32'h10) && k < 50) begin @(negedge clk); k++; end
    chk("err_found", 32'(k < 50), 32'd1);
    chk("err_before", 32'(err), 32'd0);
    hresp = 1'b1;
    @(negedge clk);
    hresp = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    chk("err_poll_addr", haddr, BASE + 32'h14);
    chk("err_poll_hwrite", 32'(hwrite), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd1);
    idle_after = 0;
    do_reset();
    check_init(init_tab);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
